// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Status-bit indices describe the packed status vector that CSR blocks assemble from the FIFO flags.
package sync_fifo_pkg;

   localparam int unsigned ST_FULL  = 0;
   localparam int unsigned ST_EMPTY = 1;
   localparam int unsigned ST_AF    = 2;
   localparam int unsigned ST_AE    = 3;
   localparam int unsigned ST_OVF   = 4;
   localparam int unsigned ST_UDF   = 5;
   localparam int unsigned ST_W     = 6;

   // Pointer width: address bits plus one wrap bit.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   // Threshold compare used by both almost flags.
   function automatic logic occ_ge(input int unsigned occ, input int unsigned level);
      return occ >= level;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port FIFO storage with one synchronous write port.
// The read port is combinational with SYNC_FIFO_FWFT_EN and registered otherwise.
module fifo_ram #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

`ifdef SYNC_FIFO_FWFT_EN
   logic unused_rd_ctrl;
   assign unused_rd_ctrl = ^{rest, re};
   assign rdata = mem[raddr];
`else
   // Output word only changes on an accepted read; it holds otherwise.
   always_ff @(posedge clk) begin
      if (rest)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, occupancy, almost thresholds, sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 1,
   parameter int unsigned AE_LEVEL = 1
) (
   input  logic                      clk,
   input  logic                      rest,
   input  logic                      wr_en,
   input  logic [WIDTH-1:0]          wr_data,
   input  logic                      rd_en,
   input  logic                      err_clr,
   output logic [WIDTH-1:0]          rd_data,
   output logic                      rd_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int unsigned PTR_W = ptr_w(DEPTH);
   localparam int unsigned AW    = PTR_W - 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_acc;
   logic             rd_acc;

   // Flags come from pointer registers only; acceptance uses this cycle's flags.
   assign count        = wr_ptr - rd_ptr;
   assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty        = (wr_ptr == rd_ptr);
   assign almost_full  = occ_ge(32'(count), AF_LEVEL);
   assign almost_empty = !occ_ge(32'(count), AE_LEVEL + 32'd1);

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_ff @(posedge clk) begin
      if (rest) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
         // A new error outranks a simultaneous clear.
         overflow  <= (wr_en && full)  || (overflow  && !err_clr);
         underflow <= (rd_en && empty) || (underflow && !err_clr);
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rd_valid = !empty;
`else
   always_ff @(posedge clk) begin
      if (rest) rd_valid <= 1'b0;
      else      rd_valid <= rd_acc;
   end
`endif

   fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .rest  (rest),
      .we    (wr_acc),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wr_data),
      .re    (rd_acc),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO with integrated storage, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow flags. It is the single-domain successor to the dual-clock pointer block, used between CNN pipeline stages that share one clock, such as line buffers and weight/feature staging. Pointers carry an extra wrap bit for full/empty discrimination, so no Gray coding or synchronisers are needed.

## Interface
- WIDTH, 16, data word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- clk  in  1  single clock, all logic on rising edge
- rest  in  1  synchronous reset, active-high
- wr_en  in  1  write request
- wr_data  in  WIDTH  write word
- rd_en  in  1  read request (standard mode) / pop acknowledge (FWFT mode)
- err_clr  in  1  clears overflow/underflow sticky flags
- rd_data  out  WIDTH  read word
- rd_valid  out  1  rd_data holds a valid word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide; the low bits address storage and the MSB is the wrap bit. Both increment modulo 2·DEPTH.
- Write is accepted iff wr_en && !full: mem[wr_ptr low] <= wr_data, wr_ptr+1.
- Read is accepted iff rd_en && !empty: rd_ptr+1.
- Acceptance of each side uses only the current-cycle flags. A write while full is dropped even if a read is accepted in the same cycle, and a read while empty is dropped even with a simultaneous write.
- count = wr_ptr − rd_ptr, computed in ptr width without a borrow bit. full = (wr MSB ≠ rd MSB) && (low bits equal). empty = (wr_ptr == rd_ptr).
- All flags and count are combinational from the pointer registers only, never from wr_en or rd_en.
- overflow sets on wr_en && full; underflow sets on rd_en && empty. Both hold until err_clr or rest. If err_clr and a new error fall in the same cycle, the set wins.
- Dropped operations leave pointers, storage and rd_data unchanged.

## Timing
- Reset values:
  - pointers, count and rd_data = 0
  - rd_valid = 0, full = 0, overflow = 0, underflow = 0
  - empty = 1, almost_empty = 1
  - almost_full = (AF_LEVEL == 0 ? 1 : 0); AF_LEVEL is ≥1, so 0
- Reset mid-operation discards all contents in one cycle. Storage contents need not be cleared.
- Accepted write at edge k: count, flags and almost flags reflect it from edge k onward, i.e. in cycle k+1.
- Standard mode: a read accepted in cycle k gives rd_data = head word and rd_valid = 1 in cycle k+1. rd_valid = 0 in any cycle following a non-accepted read, and rd_data holds its last value.
- Back-to-back reads sustain 1 word/cycle. Simultaneous accepted read and write leaves count unchanged.
- Wrap-around: after 2·DEPTH writes the pointer returns to 0. full/empty stay correct across any number of wraps.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
  - rd_data = mem[rd_ptr low] combinationally and rd_valid = !empty.
  - rd_en pops the displayed word. A word written at edge k is visible in cycle k+1.
- SYNC_FIFO_FWFT_EN undefined: standard mode with a registered read and one-cycle latency, as above.
- count, flags and error behaviour are identical in both modes.

## Structure
- Package sync_fifo_pkg holds:
  - function/constant for pointer width PTR_W = $clog2(DEPTH)+1
  - occupancy compare helper for almost-flag thresholds
  - status-bit index constants {FULL, EMPTY, AF, AE, OVF, UDF} for a packed status vector used by upstream CSR blocks
- Sub-module fifo_ram: simple dual-port storage, WIDTH×DEPTH, one synchronous write port and one read port. The read port is combinational in FWFT mode and registered in standard mode, selected by the macro.
- Top-level sync_fifo holds the pointers, flag logic and sticky error flags.

## Test plan
- Reset, then idle: empty=1, almost_empty=1, full=0, count=0, rd_valid=0, overflow=0.
- DEPTH=8: write 0x0001..0x0008 on consecutive cycles, then one more write.
  - count=8 and full=1 in the cycle after the 8th write.
  - The 9th write is dropped and overflow=1.
  - Draining yields 0x0001..0x0008 in order.
- Fill 7, then hold wr_en=rd_en=1 for 20 cycles: count stays 7, data order is preserved across pointer wrap, and full/empty never assert.
- AF_LEVEL=6, AE_LEVEL=2: almost_full rises at count 6 and falls at 5; almost_empty is 1 at count 2 and 0 at count 3.
- Read while empty: underflow=1 and rd_valid stays 0. Assert err_clr one cycle: underflow=0. Assert err_clr with a simultaneous read-while-empty: underflow stays 1.
- FWFT build: write 0xABCD at edge k; in cycle k+1 rd_valid=1 and rd_data=0xABCD with no rd_en. Pop it: rd_valid=0 next cycle. Assert rest with 5 words stored: empty=1 and count=0 the next cycle.
